pll_reconfig_seq: RTL and testbench

- Parametrised reconfiguration sequencer for the Cyclone V fractional PLL wrapper family.
- Holds a host-writable table of NUM_PROFILES counter profiles (M, N, and C0..C(NUM_CLOCKS-1)).
- On request, programs the selected profile into the PLL reconfig core over Avalon-MM, triggers reconfiguration, polls for completion, then waits for PLL lock with timeout and bounded retry.
- Sits between the host/CSR logic and the PLL's reconfig_to_pll/reconfig_from_pll core, enabling runtime frequency switching that the fixed 50->100 MHz instance cannot do.

---
 rtl/pll_reconfig_seq.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: runtime PLL reprogramming sequencer for the fractional PLL reconfig core.
// Latency: 4+NUM_CLOCKS back-to-back writes, then status polls, 2-cycle lock sync, lock wait.
// Backpressure: Avalon strobes, address and data hold while mgmt_waitrequest=1; one transfer outstanding.
//
// Ports:
//   refclk, rst              management clock, synchronous active-high reset
//   cfg_wr/profile/slot/data profile table write port (slot 0=M, 1=N, 2+k=Ck, 20+k=phase step k)
//   req_valid/req_profile    reconfiguration request, accepted only while req_ready (IDLE)
//   busy, done_pulse, fail_pulse, active_profile, retry_count   status
//   mgmt_*                   Avalon-MM master towards the PLL reconfig core
//   pll_locked               asynchronous lock indicator, synchronised here
//
// Optional build macro PLL_RECONFIG_DPS_EN: adds per-clock 16-bit phase-step slots and a
// dynamic phase-shift write phase after the C counters. Without it, slots 20+ are ignored.
// POLL_GAP is expected to be >= 1 and MAX_RETRIES <= 3 (retry_count is 2 bits).

module pll_reconfig_seq #(
   parameter int NUM_CLOCKS   = 1,
   parameter int NUM_PROFILES = 4,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRIES  = 2,
   parameter int POLL_GAP     = 15,
   localparam int PW          = $clog2(NUM_PROFILES)
) (
   input  logic          refclk,
   input  logic          rst,
   input  logic          cfg_wr,
   input  logic [PW-1:0] cfg_profile,
   input  logic [4:0]    cfg_slot,
   input  logic [17:0]   cfg_data,
   input  logic          req_valid,
   input  logic [PW-1:0] req_profile,
   output logic          req_ready,
   output logic          busy,
   output logic          done_pulse,
   output logic          fail_pulse,
   output logic [PW-1:0] active_profile,
   output logic [1:0]    retry_count,
   output logic [5:0]    mgmt_address,
   output logic          mgmt_write,
   output logic          mgmt_read,
   output logic [31:0]   mgmt_writedata,
   input  logic [31:0]   mgmt_readdata,
   input  logic          mgmt_waitrequest,
   input  logic          pll_locked
);

   localparam int CW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
   localparam int LW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_MODE, S_WR_M, S_WR_N, S_WR_C, S_DPS, S_START,
      S_POLL, S_GAP, S_LOCK_WAIT, S_RETRY, S_SUCCESS, S_FAIL
   } state_t;

   // ---------------------------------------------------------------- profile table
   logic [17:0]   m_tbl [NUM_PROFILES];
   logic [17:0]   n_tbl [NUM_PROFILES];
   logic [17:0]   c_tbl [NUM_PROFILES][NUM_CLOCKS];
   logic [CW-1:0] cfg_cidx;
   logic          cfg_prof_ok;

   assign cfg_cidx    = CW'(cfg_slot - 5'd2);
   assign cfg_prof_ok = (32'(cfg_profile) < NUM_PROFILES);

   // Table is deliberately not reset; host must program before requesting.
   always_ff @(posedge refclk) begin
      if (cfg_wr && cfg_prof_ok) begin
         if (cfg_slot == 5'd0)
            m_tbl[cfg_profile] <= cfg_data;
         else if (cfg_slot == 5'd1)
            n_tbl[cfg_profile] <= cfg_data;
         else if (32'(cfg_slot) < NUM_CLOCKS + 2)
            c_tbl[cfg_profile][cfg_cidx] <= cfg_data;
      end
   end

`ifdef PLL_RECONFIG_DPS_EN
   logic [15:0]   s_tbl [NUM_PROFILES][NUM_CLOCKS];
   logic [15:0]   lat_s [NUM_CLOCKS];
   logic [4:0]    cfg_sslot;
   assign cfg_sslot = cfg_slot - 5'd20;

   always_ff @(posedge refclk) begin
      if (cfg_wr && cfg_prof_ok && cfg_slot >= 5'd20 && 32'(cfg_sslot) < NUM_CLOCKS)
         s_tbl[cfg_profile][CW'(cfg_sslot)] <= cfg_data[15:0];
   end
`endif

   // ---------------------------------------------------------------- lock synchroniser
   logic [1:0] lock_sync;
   always_ff @(posedge refclk) begin
      if (rst) lock_sync <= '0;
      else     lock_sync <= {lock_sync[0], pll_locked};
   end

   // ---------------------------------------------------------------- sequencer
   state_t        state;
   logic [PW-1:0] lat_prof;
   logic [17:0]   lat_m, lat_n;
   logic [17:0]   lat_c [NUM_CLOCKS];
   logic [4:0]    seq_k;
   logic [4:0]    k_nxt;
   logic          last_c;
   logic [LW-1:0] lock_cnt;
   logic [GW-1:0] gap_cnt;
   logic          unused_rd;

   assign k_nxt     = seq_k + 5'd1;
   assign last_c    = (32'(seq_k) == NUM_CLOCKS - 1);
   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign unused_rd = ^mgmt_readdata[31:1];

   // Each write state keeps its strobe asserted; on completion the next transfer is loaded
   // in the same edge so writes run back-to-back when the core does not stall.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state          <= S_IDLE;
         done_pulse     <= 1'b0;
         fail_pulse     <= 1'b0;
         active_profile <= '0;
         retry_count    <= '0;
         mgmt_write     <= 1'b0;
         mgmt_read      <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         seq_k          <= '0;
         lock_cnt       <= '0;
         gap_cnt        <= '0;
      end else begin
         done_pulse <= 1'b0;
         fail_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && 32'(req_profile) < NUM_PROFILES) begin
                  // Whole profile is captured here so later table writes cannot tear it.
                  lat_prof <= req_profile;
                  lat_m    <= m_tbl[req_profile];
                  lat_n    <= n_tbl[req_profile];
                  for (int i = 0; i < NUM_CLOCKS; i++)
                     lat_c[i] <= c_tbl[req_profile][i];
`ifdef PLL_RECONFIG_DPS_EN
                  for (int i = 0; i < NUM_CLOCKS; i++)
                     lat_s[i] <= s_tbl[req_profile][i];
`endif
                  retry_count    <= '0;
                  state          <= S_MODE;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= 6'h00;
                  mgmt_writedata <= 32'd1;
               end
            end
            S_MODE: begin
               if (!mgmt_waitrequest) begin
                  state          <= S_WR_M;
                  mgmt_address   <= 6'h04;
                  mgmt_writedata <= {14'b0, lat_m};
               end
            end
            S_WR_M: begin
               if (!mgmt_waitrequest) begin
                  state          <= S_WR_N;
                  mgmt_address   <= 6'h03;
                  mgmt_writedata <= {14'b0, lat_n};
               end
            end
            S_WR_N: begin
               if (!mgmt_waitrequest) begin
                  state          <= S_WR_C;
                  seq_k          <= '0;
                  mgmt_address   <= 6'h05;
                  mgmt_writedata <= {9'b0, 5'd0, lat_c[0]};
               end
            end
            S_WR_C: begin
               if (!mgmt_waitrequest) begin
                  if (last_c) begin
`ifdef PLL_RECONFIG_DPS_EN
                     state      <= S_DPS;
                     seq_k      <= '0;
                     mgmt_write <= 1'b0;
`else
                     state          <= S_START;
                     mgmt_address   <= 6'h02;
                     mgmt_writedata <= 32'd0;
`endif
                  end else begin
                     seq_k          <= k_nxt;
                     mgmt_writedata <= {9'b0, k_nxt, lat_c[CW'(k_nxt)]};
                  end
               end
            end
            S_DPS: begin
`ifdef PLL_RECONFIG_DPS_EN
               // One cycle per clock index; a write is issued only for nonzero steps.
               // Word layout: step in [15:0], counter select in [20:16], direction [21]=0 (up).
               if (mgmt_write) begin
                  if (!mgmt_waitrequest) begin
                     mgmt_write <= 1'b0;
                     seq_k      <= k_nxt;
                  end
               end else if (32'(seq_k) >= NUM_CLOCKS) begin
                  state          <= S_START;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= 6'h02;
                  mgmt_writedata <= 32'd0;
               end else if (lat_s[CW'(seq_k)] != 16'd0) begin
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= 6'h06;
                  mgmt_writedata <= {11'b0, seq_k, lat_s[CW'(seq_k)]};
               end else begin
                  seq_k <= k_nxt;
               end
`else
               state <= S_IDLE;
`endif
            end
            S_START: begin
               if (!mgmt_waitrequest) begin
                  state          <= S_POLL;
                  mgmt_write     <= 1'b0;
                  mgmt_read      <= 1'b1;
                  mgmt_address   <= 6'h01;
                  mgmt_writedata <= 32'd0;
               end
            end
            S_POLL: begin
               if (!mgmt_waitrequest) begin
                  mgmt_read <= 1'b0;
                  lock_cnt  <= '0;
                  gap_cnt   <= '0;
                  state     <= mgmt_readdata[0] ? S_LOCK_WAIT : S_GAP;
               end
            end
            S_GAP: begin
               // Read is re-issued on the last idle cycle so exactly POLL_GAP idle cycles separate polls.
               if (32'(gap_cnt) >= POLL_GAP - 1) begin
                  state     <= S_POLL;
                  mgmt_read <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            S_LOCK_WAIT: begin
               if (lock_sync[1])
                  state <= S_SUCCESS;
               else if (32'(lock_cnt) >= LOCK_TIMEOUT)
                  state <= S_RETRY;
               else
                  lock_cnt <= lock_cnt + LW'(1);
            end
            S_RETRY: begin
               if (32'(retry_count) < MAX_RETRIES) begin
                  retry_count    <= retry_count + 2'd1;
                  state          <= S_MODE;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= 6'h00;
                  mgmt_writedata <= 32'd1;
               end else begin
                  state <= S_FAIL;
               end
            end
            S_SUCCESS: begin
               done_pulse     <= 1'b1;
               active_profile <= lat_prof;
               state          <= S_IDLE;
            end
            S_FAIL: begin
               fail_pulse <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: randomized bench for pll_reconfig_seq with a transfer-list reference model.
// Latency: not applicable (bench).
// Backpressure: the bench acts as the reconfig core and inserts random or fixed waitrequest stalls.

module tb_pll_reconfig_seq;
   localparam int NC = 3;
   localparam int NP = 3;
   localparam int LT = 100;
   localparam int MR = 2;
   localparam int PG = 15;

   logic        refclk = 1'b0;
   logic        rst;
   logic        cfg_wr;
   logic [1:0]  cfg_profile;
   logic [4:0]  cfg_slot;
   logic [17:0] cfg_data;
   logic        req_valid;
   logic [1:0]  req_profile;
   logic        req_ready, busy, done_pulse, fail_pulse;
   logic [1:0]  active_profile;
   logic [1:0]  retry_count;
   logic [5:0]  mgmt_address;
   logic        mgmt_write, mgmt_read;
   logic [31:0] mgmt_writedata;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;
   logic        pll_locked;

   always #5 refclk = ~refclk;

   pll_reconfig_seq #(
      .NUM_CLOCKS(NC), .NUM_PROFILES(NP), .LOCK_TIMEOUT(LT),
      .MAX_RETRIES(MR), .POLL_GAP(PG)
   ) dut (
      .refclk(refclk), .rst(rst),
      .cfg_wr(cfg_wr), .cfg_profile(cfg_profile), .cfg_slot(cfg_slot), .cfg_data(cfg_data),
      .req_valid(req_valid), .req_profile(req_profile), .req_ready(req_ready), .busy(busy),
      .done_pulse(done_pulse), .fail_pulse(fail_pulse),
      .active_profile(active_profile), .retry_count(retry_count),
      .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
      .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference table and last applied profile
   logic [17:0] t_m [NP];
   logic [17:0] t_n [NP];
   logic [17:0] t_c [NP][NC];
   int          exp_act = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [38:0] wr_x(input int a, input logic [31:0] d);
      logic [5:0] a6;
      a6 = 6'(a);
      return {1'b0, a6, d};
   endfunction

   function automatic logic [38:0] rd_x();
      return {1'b1, 6'h01, 32'h0};
   endfunction

   // Update the reference table only where the spec says a write lands.
   task automatic model_write(input int p, input int s, input logic [17:0] d);
      if (p < NP) begin
         if (s == 0)                       t_m[p] = d;
         else if (s == 1)                  t_n[p] = d;
         else if (s >= 2 && s < NC + 2)    t_c[p][s-2] = d;
      end
   endtask

   task automatic cfg_write(input int p, input int s, input logic [17:0] d);
      cfg_wr = 1'b1; cfg_profile = 2'(p); cfg_slot = 5'(s); cfg_data = d;
      @(negedge refclk);
      cfg_wr = 1'b0;
      model_write(p, s, d);
   endtask

   // One request: build the expected transfer list, act as the reconfig core, then compare.
   // lock_dly < 0 means the PLL never locks.
   task automatic run_req(input int prof, input int nzero, input int lock_dly, input int wmax,
                          input bit wfix, input bit mid_wr, input bit same_wr);
      logic [38:0] exp_q[$];
      logic [38:0] got_q[$];
      int          gaps[$];
      int          attempts, cyc, rd_in_att, stall_left, lock_at, last_comp, start_cyc;
      int          viol, ndone, nfail, exp_retry, mw_slot;
      bit          prev_stall, last_rd, fin, bit0;
      logic [39:0] cur, prev_sig;
      logic [31:0] rnd;
      logic [17:0] new_m, mw_data;
      logic [38:0] g;

      attempts = (lock_dly < 0) ? MR + 1 : 1;
      for (int a = 0; a < attempts; a++) begin
         exp_q.push_back(wr_x(0, 32'd1));
         exp_q.push_back(wr_x(4, {14'b0, t_m[prof]}));
         exp_q.push_back(wr_x(3, {14'b0, t_n[prof]}));
         for (int k = 0; k < NC; k++)
            exp_q.push_back(wr_x(5, (k << 18) | {14'b0, t_c[prof][k]}));
         exp_q.push_back(wr_x(2, 32'd0));
         for (int r = 0; r <= nzero; r++) exp_q.push_back(rd_x());
      end
      exp_retry = (lock_dly < 0) ? MR : 0;

      pll_locked = 1'b0;
      new_m = 18'($urandom);
      check("req_ready_before", {63'b0, req_ready}, 64'd1);
      req_valid = 1'b1; req_profile = 2'(prof);
      if (same_wr) begin
         cfg_wr = 1'b1; cfg_profile = 2'(prof); cfg_slot = 5'd0; cfg_data = new_m;
      end
      @(negedge refclk);
      req_valid = 1'b0; cfg_wr = 1'b0;
      if (same_wr) model_write(prof, 0, new_m);
      check("busy_after_accept", {63'b0, busy}, 64'd1);

      cyc = 0; rd_in_att = 0; stall_left = 0; lock_at = -1; last_comp = -1; start_cyc = 0;
      prev_stall = 1'b0; last_rd = 1'b0; viol = 0; ndone = 0; nfail = 0; fin = 1'b0;
      prev_sig = '0;
      mw_slot = $urandom_range(NC + 1, 0);
      mw_data = 18'($urandom);
      while (!fin && cyc < 4000) begin
         if (done_pulse) ndone++;
         if (fail_pulse) nfail++;
         if (done_pulse || fail_pulse) fin = 1'b1;
         cur = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
         if (prev_stall && cur != prev_sig) viol++;
         if (mgmt_write && mgmt_read) viol++;
         rnd = $urandom;
         mgmt_readdata = rnd;
         if (mgmt_write || mgmt_read) begin
            if (!prev_stall) begin
               start_cyc  = cyc;
               stall_left = wfix ? wmax : $urandom_range(wmax, 0);
            end
            if (stall_left > 0) begin
               mgmt_waitrequest = 1'b1;
               stall_left--;
            end else begin
               mgmt_waitrequest = 1'b0;
               if (mgmt_read) begin
                  got_q.push_back(rd_x());
                  if (last_rd) gaps.push_back(start_cyc - last_comp - 1);
                  rd_in_att++;
                  bit0 = (rd_in_att > nzero);
                  mgmt_readdata = {rnd[31:1], bit0};
                  if (bit0 && lock_dly >= 0) lock_at = cyc + lock_dly;
                  last_rd = 1'b1;
               end else begin
                  got_q.push_back({1'b0, mgmt_address, mgmt_writedata});
                  if (mgmt_address == 6'h02) rd_in_att = 0;
                  last_rd = 1'b0;
               end
               last_comp = cyc;
            end
            prev_stall = mgmt_waitrequest;
         end else begin
            mgmt_waitrequest = 1'($urandom_range(1, 0));
            prev_stall = 1'b0;
         end
         prev_sig = cur;
         if (lock_at >= 0 && cyc >= lock_at) pll_locked = 1'b1;
         cfg_wr = mid_wr && (cyc == 6);
         if (mid_wr && cyc == 6) begin
            cfg_profile = 2'(prof); cfg_slot = 5'(mw_slot); cfg_data = mw_data;
            model_write(prof, mw_slot, mw_data);
         end
         @(negedge refclk);
         cyc++;
      end
      cfg_wr = 1'b0;
      mgmt_waitrequest = 1'b0;

      check("finished", {63'b0, fin}, 64'd1);
      check("req_ready_after", {63'b0, req_ready}, 64'd1);
      for (int i = 0; i < 4; i++) begin
         if (done_pulse) ndone++;
         if (fail_pulse) nfail++;
         @(negedge refclk);
      end
      if (lock_dly >= 0) exp_act = prof;
      check("done_count", 64'(ndone), (lock_dly >= 0) ? 64'd1 : 64'd0);
      check("fail_count", 64'(nfail), (lock_dly < 0) ? 64'd1 : 64'd0);
      check("xfer_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : '1;
         check($sformatf("xfer%0d", i), 64'(g), 64'(exp_q[i]));
      end
      check("gap_count", 64'(gaps.size()), 64'(attempts * nzero));
      foreach (gaps[i]) check($sformatf("poll_gap%0d", i), 64'(gaps[i]), 64'(PG));
      check("avalon_stable", 64'(viol), 64'd0);
      check("retry_count", 64'(retry_count), 64'(exp_retry));
      check("active_profile", 64'(active_profile), 64'(exp_act));
   endtask

   initial begin
      int bad, found, ld;
      rst = 1'b1; cfg_wr = 1'b0; cfg_profile = '0; cfg_slot = '0; cfg_data = '0;
      req_valid = 1'b0; req_profile = '0; mgmt_readdata = '0; mgmt_waitrequest = 1'b0;
      pll_locked = 1'b0;
      repeat (3) @(negedge refclk);
      check("rst_req_ready", {63'b0, req_ready}, 64'd1);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_pulses", {62'b0, done_pulse, fail_pulse}, 64'd0);
      check("rst_active", 64'(active_profile), 64'd0);
      check("rst_retry", 64'(retry_count), 64'd0);
      check("rst_strobes", {62'b0, mgmt_write, mgmt_read}, 64'd0);
      check("rst_addr_data", {26'b0, mgmt_address, mgmt_writedata}, 64'd0);
      rst = 1'b0;
      @(negedge refclk);

      for (int p = 0; p < NP; p++)
         for (int s = 0; s < NC + 2; s++) cfg_write(p, s, 18'($urandom));
      cfg_write(1, 0, 18'h00C0C);
      cfg_write(1, 1, 18'h10101);
      cfg_write(1, 2, 18'h00606);
      // Writes that must be ignored: slot past the C counters, phase slot, missing profile
      cfg_write(0, NC + 2, 18'($urandom));
      cfg_write(0, 20, 18'($urandom));
      cfg_write(3, 0, 18'($urandom));

      run_req(1, 0, 10, 0, 1'b1, 1'b0, 1'b0);   // directed, no stalls
      run_req(1, 0, 10, 3, 1'b1, 1'b0, 1'b0);   // 3-cycle stall on every transfer
      run_req(2, 2, 5, 0, 1'b1, 1'b0, 1'b0);    // two not-done polls
      run_req(0, 0, -1, 1, 1'b0, 1'b0, 1'b0);   // never locks: full retries then fail

      // Out-of-range request is ignored
      req_valid = 1'b1; req_profile = 2'd3;
      @(negedge refclk);
      req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy || mgmt_write || mgmt_read) bad++;
         @(negedge refclk);
      end
      check("oor_ignored", 64'(bad), 64'd0);

      // Reset while the M write is stalled
      pll_locked = 1'b0;
      req_valid = 1'b1; req_profile = 2'd2;
      @(negedge refclk);
      req_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (mgmt_write && mgmt_address == 6'h04) found = 1;
         else begin
            mgmt_waitrequest = 1'b0;
            @(negedge refclk);
         end
      end
      check("reach_wr_m", 64'(found), 64'd1);
      mgmt_waitrequest = 1'b1;
      @(negedge refclk);
      check("wr_m_held", {57'b0, mgmt_write, mgmt_address}, {57'b0, 1'b1, 6'h04});
      rst = 1'b1;
      @(negedge refclk);
      check("rst_drop_write", {62'b0, mgmt_write, mgmt_read}, 64'd0);
      check("rst_ready", {62'b0, req_ready, busy}, 64'd2);
      rst = 1'b0; mgmt_waitrequest = 1'b0;
      exp_act = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (done_pulse || fail_pulse || mgmt_write || mgmt_read) bad++;
         @(negedge refclk);
      end
      check("rst_quiet", 64'(bad), 64'd0);
      check("rst_active_cleared", 64'(active_profile), 64'd0);
      run_req(2, 1, 3, 1, 1'b0, 1'b0, 1'b0);

      // Randomized requests, including simultaneous and mid-sequence table writes
      for (int it = 0; it < 8; it++) begin
         ld = ($urandom_range(5, 0) == 0) ? -1 : int'($urandom_range(60, 0));
         run_req(int'($urandom_range(NP - 1, 0)), int'($urandom_range(2, 0)), ld,
                 int'($urandom_range(2, 0)), 1'b0, 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
